// File: rtl/tama_pkg.sv
// Shared definitions for the pet front-end and the stats block: action indices,
// action bus width and the action-selector FSM state type.
package tama_pkg;

  localparam int ACTION_W  = 8;
  localparam int NUM_STATS = 6;

  localparam logic [2:0] ACT_HUNGER  = 3'd0;
  localparam logic [2:0] ACT_HAPPY   = 3'd1;
  localparam logic [2:0] ACT_HEALTH  = 3'd2;
  localparam logic [2:0] ACT_HYGIENE = 3'd3;
  localparam logic [2:0] ACT_ENERGY  = 3'd4;
  localparam logic [2:0] ACT_SOCIAL  = 3'd5;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SELECT   = 2'd1,
    ISSUE    = 2'd2,
    COOLDOWN = 2'd3
  } action_state_t;

endpackage

// File: rtl/btn_debounce.sv
// One raw push-button: 2-flop synchroniser, stable-count debounce and a
// registered one-cycle press pulse on each accepted 0->1 level change.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 270000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             level_q, level_d;
  logic             level_prev_q, level_prev_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d      = btn_raw;
    sync2_d      = sync1_q;
    level_d      = level_q;
    cnt_d        = '0;
    level_prev_d = level_q;
    press_d      = level_q & ~level_prev_q;
    // Any cycle where the synchronised level agrees with the accepted one restarts the count.
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      press_q      <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      level_q      <= level_d;
      level_prev_q <= level_prev_d;
      press_q      <= press_d;
      cnt_q        <= cnt_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/tama_action_ctrl.sv
// Menu-driven action selector: three conditioned buttons drive a cursor over the
// stats, and an accepted selection fires one registered action pulse then cools down.
module tama_action_ctrl
  import tama_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES     = 270000,
  parameter int COOLDOWN_CYCLES     = 27000000,
  parameter int MENU_TIMEOUT_CYCLES = 135000000,
  parameter int NUM_ACTIONS         = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                btn_next,
  input  logic                btn_ok,
  input  logic                btn_cancel,
  output logic [ACTION_W-1:0] action_pulse,
  output logic [2:0]          cursor,
  output logic                menu_open,
  output logic                busy
);

  localparam int CD_W = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;
  localparam int TO_W = (MENU_TIMEOUT_CYCLES > 1) ? $clog2(MENU_TIMEOUT_CYCLES) : 1;
  localparam logic [CD_W-1:0]     CD_LAST     = CD_W'(COOLDOWN_CYCLES - 1);
  localparam logic [TO_W-1:0]     TO_LAST     = TO_W'(MENU_TIMEOUT_CYCLES - 1);
  localparam logic [2:0]          CURSOR_LAST = 3'(NUM_ACTIONS - 1);
  localparam logic [ACTION_W-1:0] ACTION_MASK = ACTION_W'((1 << NUM_ACTIONS) - 1);

  logic press_next, press_ok, press_cancel;
  logic ev_next, ev_ok, ev_cancel;

  action_state_t       state_q, state_d;
  logic [2:0]          cursor_q, cursor_d;
  logic [CD_W-1:0]     cd_cnt_q, cd_cnt_d;
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
  logic [ACTION_W-1:0] action_pulse_q, action_pulse_d;
  logic                menu_open_q, menu_open_d;
  logic                busy_q, busy_d;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
    .clk(clk), .reset(reset), .btn_raw(btn_next), .press(press_next)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ok (
    .clk(clk), .reset(reset), .btn_raw(btn_ok), .press(press_ok)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cancel (
    .clk(clk), .reset(reset), .btn_raw(btn_cancel), .press(press_cancel)
  );

  // Only the highest-priority event of a cycle survives: cancel > ok > next.
  assign ev_cancel = press_cancel;
  assign ev_ok     = press_ok & ~press_cancel;
  assign ev_next   = press_next & ~press_ok & ~press_cancel;

  always_comb begin
    state_d  = state_q;
    cursor_d = cursor_q;
    cd_cnt_d = '0;
    to_cnt_d = '0;
    case (state_q)
      IDLE: begin
        if (ev_ok || ev_next) begin
          state_d  = SELECT;
          cursor_d = 3'd0;
        end
      end
      SELECT: begin
        if (ev_cancel) begin
          state_d = IDLE;
        end else if (ev_ok) begin
          state_d = ISSUE;
        end else if (ev_next) begin
          cursor_d = (cursor_q == CURSOR_LAST) ? 3'd0 : cursor_q + 3'd1;
        end else if (to_cnt_q == TO_LAST) begin
          state_d = IDLE;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      ISSUE: begin
        state_d = COOLDOWN;
      end
      COOLDOWN: begin
        // Events arriving here are simply not looked at, so nothing queues up.
        if (cd_cnt_q == CD_LAST) begin
          state_d = IDLE;
        end else begin
          cd_cnt_d = cd_cnt_q + CD_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_comb begin
    action_pulse_d = '0;
    if (state_d == ISSUE) begin
      action_pulse_d = (ACTION_W'(1) << cursor_d) & ACTION_MASK;
    end
    menu_open_d = (state_d == SELECT);
    busy_d      = (state_d == ISSUE) || (state_d == COOLDOWN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      cursor_q       <= 3'd0;
      cd_cnt_q       <= '0;
      to_cnt_q       <= '0;
      action_pulse_q <= '0;
      menu_open_q    <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cursor_q       <= cursor_d;
      cd_cnt_q       <= cd_cnt_d;
      to_cnt_q       <= to_cnt_d;
      action_pulse_q <= action_pulse_d;
      menu_open_q    <= menu_open_d;
      busy_q         <= busy_d;
    end
  end

  assign action_pulse = action_pulse_q;
  assign cursor       = cursor_q;
  assign menu_open    = menu_open_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_tama_action_ctrl.sv
// Self-checking bench for tama_action_ctrl with short debounce/cooldown/timeout
// values; action pulses are matched against an expected queue by a monitor.
module tb_tama_action_ctrl;
  import tama_pkg::*;

  localparam int DB = 4;
  localparam int CD = 10;
  localparam int TO = 20;
  localparam int NA = 6;

  logic                clk = 1'b0;
  logic                reset;
  logic                btn_next, btn_ok, btn_cancel;
  logic [ACTION_W-1:0] action_pulse;
  logic [2:0]          cursor;
  logic                menu_open, busy;

  int                  vec_cnt = 0;
  int                  err_cnt = 0;
  logic [7:0]          exp_q[$];
  logic [7:0]          exp_v;
  logic [7:0]          prev_pulse = 8'h00;

  tama_action_ctrl #(
    .DEBOUNCE_CYCLES(DB), .COOLDOWN_CYCLES(CD),
    .MENU_TIMEOUT_CYCLES(TO), .NUM_ACTIONS(NA)
  ) dut (
    .clk(clk), .reset(reset),
    .btn_next(btn_next), .btn_ok(btn_ok), .btn_cancel(btn_cancel),
    .action_pulse(action_pulse), .cursor(cursor),
    .menu_open(menu_open), .busy(busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard: every nonzero pulse must match the head of exp_q and last one cycle
  always @(negedge clk) begin
    if (reset) begin
      prev_pulse = 8'h00;
    end else begin
      if (action_pulse !== 8'h00) begin
        vec_cnt++;
        if (exp_q.size() == 0) begin
          err_cnt++;
          $display("FAIL unexpected_pulse: got %h, expected no pulse", action_pulse);
        end else begin
          exp_v = exp_q.pop_front();
          if (action_pulse !== exp_v) begin
            err_cnt++;
            $display("FAIL pulse_value: got %h, expected %h", action_pulse, exp_v);
          end
        end
        if (prev_pulse !== 8'h00) begin
          err_cnt++;
          $display("FAIL pulse_width: got pulse %h following %h, expected single cycle", action_pulse, prev_pulse);
        end
      end
      prev_pulse = action_pulse;
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_btn(input int which, input logic val);
    case (which)
      0: btn_next = val;
      1: btn_ok = val;
      default: btn_cancel = val;
    endcase
  endtask

  // clean press: event lands after 7 edges, state visible after 8, then release settles
  task automatic press(input int which);
    set_btn(which, 1'b1);
    tick(8);
    set_btn(which, 1'b0);
    tick(7);
  endtask

  task automatic issue_check(input logic [7:0] exp_pulse);
    exp_q.push_back(exp_pulse);
    btn_ok = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      if (i == 8) btn_ok = 1'b0;
      vec_cnt++;
      if (busy !== (i >= 8 && i <= 18) || menu_open !== (i < 8)) begin
        err_cnt++;
        $display("FAIL issue_flags step %0d: got busy=%b menu_open=%b, expected busy=%b menu_open=%b",
                 i, busy, menu_open, (i >= 8 && i <= 18), (i < 8));
      end
      if (i == 8) begin
        vec_cnt++;
        if (action_pulse !== exp_pulse) begin
          err_cnt++;
          $display("FAIL issue_pulse: got %h, expected %h", action_pulse, exp_pulse);
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; btn_next = 1'b0; btn_ok = 1'b0; btn_cancel = 1'b0;
    tick(3);
    vec_cnt++;
    if ({action_pulse, cursor, menu_open, busy} !== 13'h0) begin
      err_cnt++;
      $display("FAIL reset_state: got pulse=%h cursor=%0d menu_open=%b busy=%b, expected all 0",
               action_pulse, cursor, menu_open, busy);
    end
    reset = 1'b0;
    tick(2);
  endtask

  task automatic test_bounce();
    logic saw_open;
    saw_open = 1'b0;
    for (int i = 0; i < 6; i++) begin
      btn_ok = (i % 2 == 0);
      repeat (2) begin
        tick(1);
        if (menu_open !== 1'b0 || busy !== 1'b0) saw_open = 1'b1;
      end
    end
    vec_cnt++;
    if (saw_open !== 1'b0) begin
      err_cnt++;
      $display("FAIL bounce_filter: got state change during bounce, expected none");
    end
    btn_ok = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick(1);
      vec_cnt++;
      if (menu_open !== (i >= 8)) begin
        err_cnt++;
        $display("FAIL bounce_press_time step %0d: got menu_open=%b, expected %b", i, menu_open, (i >= 8));
      end
    end
    vec_cnt++;
    if (cursor !== 3'd0) begin
      err_cnt++;
      $display("FAIL bounce_cursor: got %0d, expected 0", cursor);
    end
    btn_ok = 1'b0;
    tick(7);
    press(2);
    vec_cnt++;
    if (menu_open !== 1'b0) begin
      err_cnt++;
      $display("FAIL cancel_close: got menu_open=%b, expected 0", menu_open);
    end
  endtask

  task automatic test_nav();
    press(1);
    vec_cnt++;
    if (menu_open !== 1'b1 || cursor !== 3'd0) begin
      err_cnt++;
      $display("FAIL nav_open: got menu_open=%b cursor=%0d, expected 1 and 0", menu_open, cursor);
    end
    for (int k = 1; k <= 3; k++) begin
      press(0);
      vec_cnt++;
      if (cursor !== 3'(k)) begin
        err_cnt++;
        $display("FAIL nav_cursor: got %0d, expected %0d", cursor, k);
      end
    end
    issue_check(8'h08);
  endtask

  task automatic test_wrap();
    press(1);
    vec_cnt++;
    if (cursor !== 3'd0) begin
      err_cnt++;
      $display("FAIL wrap_open_cursor: got %0d, expected 0", cursor);
    end
    for (int k = 1; k <= 6; k++) begin
      press(0);
      vec_cnt++;
      if (cursor !== 3'(k % NA)) begin
        err_cnt++;
        $display("FAIL wrap_cursor: got %0d, expected %0d", cursor, k % NA);
      end
    end
    issue_check(8'h01);
  endtask

  task automatic test_cooldown_drop();
    press(1);
    exp_q.push_back(8'h01);
    btn_ok = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      tick(1);
      if (i == 5) btn_ok = 1'b0;
      if (i == 8) btn_ok = 1'b1;
      if (i == 30) btn_ok = 1'b0;
      vec_cnt++;
      if (busy !== (i >= 8 && i <= 18) || menu_open !== (i < 8)) begin
        err_cnt++;
        $display("FAIL cooldown_flags step %0d: got busy=%b menu_open=%b, expected busy=%b menu_open=%b",
                 i, busy, menu_open, (i >= 8 && i <= 18), (i < 8));
      end
    end
  endtask

  task automatic test_timeout_priority();
    btn_ok = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      tick(1);
      if (i == 8) btn_ok = 1'b0;
      vec_cnt++;
      if (menu_open !== (i >= 8 && i < 28)) begin
        err_cnt++;
        $display("FAIL timeout step %0d: got menu_open=%b, expected %b", i, menu_open, (i >= 8 && i < 28));
      end
    end
    press(1);
    press(0);
    btn_cancel = 1'b1;
    btn_ok = 1'b1;
    tick(8);
    vec_cnt++;
    if (menu_open !== 1'b0 || busy !== 1'b0 || cursor !== 3'd1) begin
      err_cnt++;
      $display("FAIL priority: got menu_open=%b busy=%b cursor=%0d, expected 0 0 1", menu_open, busy, cursor);
    end
    btn_cancel = 1'b0;
    btn_ok = 1'b0;
    tick(7);
  endtask

  task automatic reset_abort(input int extra, input logic [7:0] exp_pulse, input int n_next);
    press(1);
    for (int k = 0; k < n_next; k++) press(0);
    exp_q.push_back(exp_pulse);
    btn_ok = 1'b1;
    tick(8);
    btn_ok = 1'b0;
    tick(extra);
    vec_cnt++;
    if (busy !== 1'b1) begin
      err_cnt++;
      $display("FAIL abort_busy_before: got busy=%b, expected 1", busy);
    end
    #2 reset = 1'b1;
    #1;
    vec_cnt++;
    if ({action_pulse, cursor, menu_open, busy} !== 13'h0) begin
      err_cnt++;
      $display("FAIL abort_immediate: got pulse=%h cursor=%0d menu_open=%b busy=%b, expected all 0",
               action_pulse, cursor, menu_open, busy);
    end
    tick(3);
    reset = 1'b0;
    tick(20);
    vec_cnt++;
    if ({action_pulse, cursor, menu_open, busy} !== 13'h0) begin
      err_cnt++;
      $display("FAIL abort_after_release: got pulse=%h cursor=%0d menu_open=%b busy=%b, expected all 0",
               action_pulse, cursor, menu_open, busy);
    end
  endtask

  task automatic test_reset_mid();
    reset_abort(0, 8'h02, 1);
    reset_abort(3, 8'h04, 2);
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_nav();
    test_wrap();
    test_cooldown_drop();
    test_timeout_priority();
    test_reset_mid();
    tick(2);
    vec_cnt++;
    if (exp_q.size() != 0) begin
      err_cnt++;
      $display("FAIL missing_pulses: got %0d expected pulses never seen, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
